pipe_stage_reg: RTL and testbench

- Generic, parametrised pipeline stage register; successor to the fixed-width stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds valid/ready handshake, optional 2-entry skid buffer, multiple OR-reduced stall and flush sources, selectable stall/flush priority and a saturating stall-cycle counter.
- Sits between any two CPU pipeline stages; the payload is an opaque bus assembled by the instantiating stage.

---
 rtl/pipe_stage_reg_pkg.sv | 17 +
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_stage_reg.sv | 111 +++++++++++
 tb/tb_pipe_stage_reg.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the generic pipeline stage register: state encoding
// and default payload widths at each CPU stage boundary.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } ps_state_e;

  localparam int unsigned IF_ID_W   = 96;
  localparam int unsigned ID_EX_W   = 279;
  localparam int unsigned EX_MEM_W  = 180;
  localparam int unsigned MEM_WB_W  = 110;
  localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, optional
// skid entry, OR-reduced stall/flush sources and a saturating stall counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W           = 279,
  parameter logic [DATA_W-1:0] RST_VAL          = {DATA_W{1'b0}},
  parameter int                N_STALL          = 1,
  parameter int                N_FLUSH          = 2,
  parameter int                SKID_EN          = 1,
  parameter int                FLUSH_OVER_STALL = 0,
  parameter int                CNT_W            = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_STALL-1:0] stall_req,
  input  logic [N_FLUSH-1:0] flush_req,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         occ,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic L_SKID = (SKID_EN != 0);
  localparam logic L_FOS  = (FLUSH_OVER_STALL != 0);

  ps_state_e         r_state, w_state_nxt;
  logic [DATA_W-1:0] r_main, w_main_nxt;
  logic [DATA_W-1:0] r_skid, w_skid_nxt;

  logic w_stall, w_flush, w_frz, w_kill;
  logic w_in_fire, w_out_fire, w_room;

  assign w_stall = |stall_req;
  assign w_flush = |flush_req;
  assign w_frz   = w_stall & ~(w_flush & L_FOS);
  assign w_kill  = w_flush & ~w_frz;

  // Without the skid entry, a full stage can only accept while the head leaves.
  assign w_room    = L_SKID ? (r_state != PS_TWO) : ((r_state == PS_EMPTY) | out_ready);
  assign in_ready  = w_room & ~w_frz & ~w_kill & ~rst;
  assign out_valid = (r_state != PS_EMPTY) & ~w_frz;
  assign out_data  = r_main;
  assign occ       = 2'(r_state);

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (!w_frz) begin
      if (w_kill) begin
        w_state_nxt = PS_EMPTY;
        w_main_nxt  = RST_VAL;
        w_skid_nxt  = RST_VAL;
      end else begin
        case (r_state)
          PS_EMPTY: begin
            if (w_in_fire) begin
              w_state_nxt = PS_ONE;
              w_main_nxt  = in_data;
            end
          end
          PS_ONE: begin
            if (w_in_fire && w_out_fire) begin
              w_main_nxt = in_data;
            end else if (w_out_fire) begin
              w_state_nxt = PS_EMPTY;
            end else if (w_in_fire && L_SKID) begin
              w_state_nxt = PS_TWO;
              w_skid_nxt  = in_data;
            end
          end
          PS_TWO: begin
            if (w_out_fire) begin
              w_state_nxt = PS_ONE;
              w_main_nxt  = r_skid;
            end
          end
          default: w_state_nxt = PS_EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PS_EMPTY;
      r_main  <= RST_VAL;
      r_skid  <= RST_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_frz & (r_state != PS_EMPTY)),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (skid/stall-priority/4-bit counter and
// pass-through/flush-priority) checked against a FIFO-level reference model.
module tb_pipe_stage_reg;

  localparam int          DW = 16;
  localparam logic [15:0] RV = 16'h5A5A;

  typedef struct packed {
    logic        ov;
    logic        ir;
    logic [15:0] od;
    logic [1:0]  occ;
    logic [15:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [0:0]  st   [2];
  logic [1:0]  fl   [2];
  logic        iv   [2];
  logic [15:0] id   [2];
  logic        ordy [2];

  logic        ov_a, ir_a, ov_b, ir_b;
  logic [15:0] od_a, od_b;
  logic [1:0]  occ_a, occ_b;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;

  pipe_stage_reg #(.DATA_W(DW), .RST_VAL(RV), .N_STALL(1), .N_FLUSH(2),
                   .SKID_EN(1), .FLUSH_OVER_STALL(0), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .stall_req(st[0]), .flush_req(fl[0]),
    .in_valid(iv[0]), .in_ready(ir_a), .in_data(id[0]),
    .out_valid(ov_a), .out_ready(ordy[0]), .out_data(od_a),
    .occ(occ_a), .stall_cnt(cnt_a)
  );

  pipe_stage_reg #(.DATA_W(DW), .RST_VAL(RV), .N_STALL(1), .N_FLUSH(2),
                   .SKID_EN(0), .FLUSH_OVER_STALL(1), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .stall_req(st[1]), .flush_req(fl[1]),
    .in_valid(iv[1]), .in_ready(ir_b), .in_data(id[1]),
    .out_valid(ov_b), .out_ready(ordy[1]), .out_data(od_b),
    .occ(occ_b), .stall_cnt(cnt_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most 2 (or 1) entries per instance.
  logic [15:0] m_buf  [2][2];
  int          m_n    [2];
  logic [15:0] m_last [2];
  int          m_cnt  [2];
  int          m_cmax [2];
  bit          m_skid [2];
  bit          m_fos  [2];
  logic        m_xin  [2];
  logic        m_xout [2];
  logic        m_xfrz [2];
  logic        m_xkill[2];

  logic [15:0] rec [4];
  int          rec_n;
  bit          rec_on;

  function automatic obs_t get_obs(input int i);
    obs_t o;
    if (i == 0) begin
      o.ov = ov_a; o.ir = ir_a; o.od = od_a; o.occ = occ_a; o.cnt = {12'd0, cnt_a};
    end else begin
      o.ov = ov_b; o.ir = ir_b; o.od = od_b; o.occ = occ_b; o.cnt = cnt_b;
    end
    return o;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      m_n[i]    = 0;
      m_last[i] = RV;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic check_comb(input int i);
    obs_t        o;
    logic        frz, kill, e_ov, e_ir;
    logic [15:0] e_od;
    string       p;
    o    = get_obs(i);
    p    = (i == 0) ? "a" : "b";
    frz  = st[i][0] & ~((|fl[i]) & m_fos[i]);
    kill = (|fl[i]) & ~frz;
    e_ov = (m_n[i] > 0) & ~frz;
    e_ir = (m_skid[i] ? (m_n[i] < 2) : (m_n[i] == 0 || ordy[i])) & ~frz & ~kill;
    e_od = (m_n[i] > 0) ? m_buf[i][0] : m_last[i];
    chk({p, ".out_valid"}, 32'(o.ov), 32'(e_ov));
    chk({p, ".in_ready"},  32'(o.ir), 32'(e_ir));
    chk({p, ".out_data"},  32'(o.od), 32'(e_od));
    chk({p, ".occ"},       32'(o.occ), 32'(m_n[i]));
    chk({p, ".stall_cnt"}, 32'(o.cnt), 32'(m_cnt[i]));
    m_xin[i]   = iv[i] & e_ir;
    m_xout[i]  = e_ov & ordy[i];
    m_xfrz[i]  = frz;
    m_xkill[i] = kill;
  endtask

  task automatic advance(input int i);
    if (m_xfrz[i]) begin
      if (m_n[i] > 0 && m_cnt[i] < m_cmax[i]) m_cnt[i]++;
    end else if (m_xkill[i]) begin
      m_n[i]    = 0;
      m_last[i] = RV;
    end else begin
      if (m_xout[i]) begin
        m_last[i]   = m_buf[i][0];
        m_buf[i][0] = m_buf[i][1];
        m_n[i]--;
      end
      if (m_xin[i]) begin
        m_buf[i][m_n[i]] = id[i];
        m_n[i]++;
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_comb(0);
    check_comb(1);
    if (rec_on && ov_a && ordy[0] && rec_n < 4) begin
      rec[rec_n] = od_a;
      rec_n++;
    end
    @(posedge clk);
    advance(0);
    advance(1);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic [1:0] f, input logic v,
                       input logic [15:0] d, input logic r);
    for (int i = 0; i < 2; i++) begin
      st[i] = s; fl[i] = f; iv[i] = v; id[i] = d; ordy[i] = r;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_cmax = '{15, 65535};
    m_skid = '{1'b1, 1'b0};
    m_fos  = '{1'b0, 1'b1};
    rec_n  = 0;
    rec_on = 1'b0;
    rst    = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 16'h0, 1'b0);
    reset_model();
    #2;
    chk("rst.out_valid_a", 32'(ov_a), 32'd0);
    chk("rst.in_ready_a",  32'(ir_a), 32'd0);
    chk("rst.in_ready_b",  32'(ir_b), 32'd0);
    chk("rst.out_data_a",  32'(od_a), 32'(RV));
    chk("rst.occ_b",       32'(occ_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-pressure: three words against a blocked sink.
    rec_on = 1'b1;
    drive(1'b0, 2'b00, 1'b1, 16'h1, 1'b0); cycle();
    drive(1'b0, 2'b00, 1'b1, 16'h2, 1'b0); cycle();
    drive(1'b0, 2'b00, 1'b1, 16'h3, 1'b0); cycle();
    chk("bp.occ_a",      32'(occ_a), 32'd2);
    chk("bp.in_ready_a", 32'(ir_a),  32'd0);
    drive(1'b0, 2'b00, 1'b1, 16'h3, 1'b1); cycle(); cycle();
    drive(1'b0, 2'b00, 1'b0, 16'h0, 1'b1); cycle(); cycle(); cycle();
    rec_on = 1'b0;
    chk("bp.count", 32'(rec_n), 32'd3);
    chk("bp.word0", 32'(rec[0]), 32'h1);
    chk("bp.word1", 32'(rec[1]), 32'h2);
    chk("bp.word2", 32'(rec[2]), 32'h3);

    // Stall together with flush; a holds (stall priority), b empties (flush priority).
    drive(1'b0, 2'b00, 1'b1, 16'h77, 1'b0); cycle();
    drive(1'b1, 2'b01, 1'b0, 16'h0, 1'b0); cycle();
    chk("sf.occ_a",       32'(occ_a), 32'd1);
    chk("sf.out_valid_a", 32'(ov_a),  32'd0);
    chk("sf.out_data_a",  32'(od_a),  32'h77);
    chk("sf.occ_b",       32'(occ_b), 32'd0);
    chk("sf.out_data_b",  32'(od_b),  32'(RV));
    drive(1'b0, 2'b01, 1'b0, 16'h0, 1'b0); cycle();
    chk("sf.flush_occ_a",  32'(occ_a), 32'd0);
    chk("sf.flush_data_a", 32'(od_a),  32'(RV));
    drive(1'b0, 2'b00, 1'b0, 16'h0, 1'b0); cycle();

    // Stall counter saturation and no counting while empty.
    drive(1'b0, 2'b00, 1'b1, 16'hC3, 1'b0); cycle();
    drive(1'b1, 2'b00, 1'b0, 16'h0, 1'b0);
    repeat (20) cycle();
    chk("cnt.sat_a",  32'(cnt_a), 32'd15);
    chk("cnt.full_b", 32'(cnt_b), 32'd20);
    drive(1'b0, 2'b10, 1'b0, 16'h0, 1'b0); cycle();
    drive(1'b1, 2'b00, 1'b0, 16'h0, 1'b0);
    repeat (5) cycle();
    chk("cnt.empty_a", 32'(cnt_a), 32'd15);
    chk("cnt.empty_b", 32'(cnt_b), 32'd20);
    drive(1'b0, 2'b00, 1'b0, 16'h0, 1'b0); cycle();

    // Asynchronous reset while full.
    drive(1'b0, 2'b00, 1'b1, 16'hA, 1'b0); cycle();
    drive(1'b0, 2'b00, 1'b1, 16'hB, 1'b0); cycle();
    chk("ar.pre_occ_a", 32'(occ_a), 32'd2);
    drive(1'b0, 2'b00, 1'b0, 16'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("ar.out_valid_a", 32'(ov_a),  32'd0);
    chk("ar.occ_a",       32'(occ_a), 32'd0);
    chk("ar.out_data_a",  32'(od_a),  32'(RV));
    chk("ar.in_ready_a",  32'(ir_a),  32'd0);
    chk("ar.stall_cnt_a", 32'(cnt_a), 32'd0);
    chk("ar.occ_b",       32'(occ_b), 32'd0);
    chk("ar.out_data_b",  32'(od_b),  32'(RV));
    reset_model();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic on both instances.
    repeat (1500) begin
      for (int i = 0; i < 2; i++) begin
        st[i]   = 1'($urandom_range(0, 7) == 0);
        fl[i]   = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        iv[i]   = 1'($urandom_range(0, 3) != 0);
        id[i]   = 16'($urandom);
        ordy[i] = 1'($urandom);
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
